// File: rtl/mem_arb_pkg.sv
// Shared definitions for the mem_arb memory-port arbiter: FSM states,
// grant bit positions and the default SRAM address window.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_AXIS = 0;
  localparam int GNT_IFU  = 1;
  localparam int GNT_AGU  = 2;

  localparam logic [15:0] SRAM_BASE_DEF = 16'h8000;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: axis > ifu > agu, except that an aged agu
// request jumps ahead of everyone. Produces a one-hot grant (or all zero).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       axis_val,
  input  logic       ifu_val,
  input  logic       agu_val,
  input  logic       agu_aged,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    if (agu_val && agu_aged) begin
      gnt[GNT_AGU] = 1'b1;
    end else if (axis_val) begin
      gnt[GNT_AXIS] = 1'b1;
    end else if (ifu_val) begin
      gnt[GNT_IFU] = 1'b1;
    end else if (agu_val) begin
      gnt[GNT_AGU] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Three-requester arbiter for the core memory port, routing to SRAM or AXI.
// Optional ISSUE-state watchdog with o_err is enabled by CIRNO9_ARB_TIMEOUT_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE  = SRAM_BASE_DEF,
  parameter int          STARVE_MAX = 8
`ifdef CIRNO9_ARB_TIMEOUT_EN
  , parameter int        TIMEOUT    = 256
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_axis4arb_val,
  output logic        hs_arb4axis_rdy,
  input  logic [31:0] i_axis_adr,
  input  logic [31:0] i_axis_wdat,
  input  logic [3:0]  i_axis_wen,
  input  logic        i_axis_ren,
  input  logic        hs_ifu4arb_val,
  output logic        hs_arb4ifu_rdy,
  input  logic [31:0] i_ifu_pc,
  input  logic        hs_agu4arb_val,
  output logic        hs_arb4agu_rdy,
  input  logic [31:0] i_agu_adr,
  input  logic [31:0] i_agu_wdat,
  input  logic [3:0]  i_agu_wen,
  input  logic        i_agu_ren,
  output logic        o_sram_ren,
  output logic [3:0]  o_sram_wen,
  input  logic        hs_ram4arb_rdy,
  input  logic [31:0] i_sram_rdat,
  output logic        hs_arb4axim_val,
  output logic        o_axim_ren,
  output logic [3:0]  o_axim_wen,
  input  logic        hs_axim4arb_rdy,
  input  logic [31:0] i_axim_rdat,
  output logic [31:0] o_adr,
  output logic [31:0] o_wdat,
`ifdef CIRNO9_ARB_TIMEOUT_EN
  output logic        o_err,
`endif
  output logic [31:0] o_rdat
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [3:0]    wen_q, wen_d;
  logic          ren_q, ren_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [2:0]    pick_gnt;
  logic          sel_sram;
  logic          tgt_rdy;
  logic [31:0]   tgt_rdat;
  logic          issue_end;

  assign sel_sram = (adr_q[31:16] == SRAM_BASE);
  assign tgt_rdy  = sel_sram ? hs_ram4arb_rdy : hs_axim4arb_rdy;
  assign tgt_rdat = sel_sram ? i_sram_rdat : i_axim_rdat;

`ifdef CIRNO9_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1)) && !tgt_rdy;
  assign issue_end = tgt_rdy || tmo_hit;
  assign o_err     = err_q;
`else
  assign issue_end = tgt_rdy;
`endif

  mem_arb_pick u_pick (
    .axis_val (hs_axis4arb_val),
    .ifu_val  (hs_ifu4arb_val),
    .agu_val  (hs_agu4arb_val),
    .agu_aged (starve_q == SW'(STARVE_MAX)),
    .gnt      (pick_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (|pick_gnt) state_d = ARB_ISSUE;
      ARB_ISSUE: if (issue_end) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Request latch, aging counter and read-data capture
  always_comb begin
    gnt_d    = gnt_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    wen_d    = wen_q;
    ren_d    = ren_q;
    rdat_d   = rdat_q;
    starve_d = starve_q;
`ifdef CIRNO9_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = err_q;
`endif
    case (state_q)
      ARB_IDLE: begin
`ifdef CIRNO9_ARB_TIMEOUT_EN
        tmo_d = '0;
        err_d = 1'b0;
`endif
        if (|pick_gnt) gnt_d = pick_gnt;
        if (pick_gnt[GNT_AXIS]) begin
          adr_d  = i_axis_adr;
          wdat_d = i_axis_wdat;
          wen_d  = i_axis_wen;
          ren_d  = i_axis_ren && (i_axis_wen == 4'h0);
        end else if (pick_gnt[GNT_IFU]) begin
          adr_d  = i_ifu_pc;
          wdat_d = '0;
          wen_d  = '0;
          ren_d  = 1'b1;
        end else if (pick_gnt[GNT_AGU]) begin
          adr_d  = i_agu_adr;
          wdat_d = i_agu_wdat;
          wen_d  = i_agu_wen;
          ren_d  = i_agu_ren && (i_agu_wen == 4'h0);
        end
        if (!hs_agu4arb_val || pick_gnt[GNT_AGU]) begin
          starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
          starve_d = starve_q + SW'(1);
        end
      end
      ARB_ISSUE: begin
`ifdef CIRNO9_ARB_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          rdat_d = 32'hDEAD_BEEF;
          err_d  = 1'b1;
        end
`endif
        if (tgt_rdy && ren_q) rdat_d = tgt_rdat;
      end
      ARB_DONE: begin
`ifdef CIRNO9_ARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      wen_q    <= '0;
      ren_q    <= 1'b0;
      rdat_q   <= '0;
      starve_q <= '0;
`ifdef CIRNO9_ARB_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      gnt_q    <= gnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      rdat_q   <= rdat_d;
      starve_q <= starve_d;
`ifdef CIRNO9_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decode from registered state only, so reset clears them at once
  always_comb begin
    o_sram_ren      = 1'b0;
    o_sram_wen      = 4'h0;
    hs_arb4axim_val = 1'b0;
    o_axim_ren      = 1'b0;
    o_axim_wen      = 4'h0;
    o_adr           = '0;
    o_wdat          = '0;
    hs_arb4axis_rdy = 1'b0;
    hs_arb4ifu_rdy  = 1'b0;
    hs_arb4agu_rdy  = 1'b0;
    case (state_q)
      ARB_ISSUE: begin
        o_adr  = adr_q;
        o_wdat = wdat_q;
        if (sel_sram) begin
          o_sram_ren = ren_q;
          o_sram_wen = wen_q;
        end else begin
          hs_arb4axim_val = 1'b1;
          o_axim_ren      = ren_q;
          o_axim_wen      = wen_q;
        end
      end
      ARB_DONE: begin
        hs_arb4axis_rdy = gnt_q[GNT_AXIS];
        hs_arb4ifu_rdy  = gnt_q[GNT_IFU];
        hs_arb4agu_rdy  = gnt_q[GNT_AGU];
      end
      default: ;
    endcase
  end

  assign o_rdat = rdat_q;

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Sequential arbiter/scheduler sharing the single core memory port between three requesters: AXI-slave DMA (axis), instruction fetch (ifu) and load/store address generator (agu).
- Registers the grant and holds it until the target completes, so multi-cycle AXI master transactions can be serviced.
- Routes each transaction to tightly-coupled SRAM or the AXI master, and returns registered read data.
- Includes anti-starvation aging for agu; sits between core/DMA front-ends and the SRAM/AXI-master targets.

Parameters:
- SRAM_BASE, 16'h8000, value of adr[31:16] that selects SRAM; any other value selects AXI master.
- STARVE_MAX, 8, number of consecutive lost arbitrations after which a pending agu request is promoted to top priority.
- TIMEOUT, 256, ISSUE-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hs_axis4arb_val  in  1; hs_arb4axis_rdy  out  1; i_axis_adr  in  32; i_axis_wdat  in  32; i_axis_wen  in  4; i_axis_ren  in  1
- hs_ifu4arb_val  in  1; hs_arb4ifu_rdy  out  1; i_ifu_pc  in  32 (read-only, word)
- hs_agu4arb_val  in  1; hs_arb4agu_rdy  out  1; i_agu_adr  in  32; i_agu_wdat  in  32; i_agu_wen  in  4; i_agu_ren  in  1
- o_sram_ren  out  1; o_sram_wen  out  4; hs_ram4arb_rdy  in  1; i_sram_rdat  in  32
- hs_arb4axim_val  out  1; o_axim_ren  out  1; o_axim_wen  out  4; hs_axim4arb_rdy  in  1; i_axim_rdat  in  32
- o_adr  out  32; o_wdat  out  32; o_rdat  out  32 (registered, valid in the rdy cycle)
- o_err  out  1 (present only with CIRNO9_ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all rdy, val, ren, wen outputs 0; o_adr, o_wdat, o_rdat = 0; starve_cnt = 0; grant = none.
- Requesters hold val and payload stable until their rdy pulses. rdy is a one-cycle pulse. Transfer occurs on val&rdy.
- States:
  - IDLE: if any val, pick winner, latch grant id, adr, wdat, wen, ren into registers, then go to ISSUE. Otherwise stay.
  - ISSUE: drive latched request to the selected target (SRAM when adr[31:16]==SRAM_BASE). Unselected target outputs are 0. hs_arb4axim_val=1 only when AXI is selected. When the selected target's rdy=1, capture the matching rdat into o_rdat (reads only; writes leave o_rdat unchanged) and go to DONE. Target outputs drop to 0 the next cycle.
  - DONE: pulse rdy to the granted requester for exactly one cycle, then go to IDLE. Target outputs are 0.
- ifu requests drive ren=1 and wen=0.
- Latency: minimum 3 cycles from val seen in IDLE to rdy (IDLE→ISSUE→DONE) with zero-wait target.
- Priority: axis > ifu > agu. Exception: if starve_cnt==STARVE_MAX and agu val=1, agu wins over all.
- starve_cnt: increments (saturating at STARVE_MAX) each IDLE arbitration that agu loses while its val=1. Clears when agu is granted or agu val=0 in IDLE.
- Simultaneous: a new val arriving during ISSUE/DONE waits. A requester whose rdy pulses in DONE may re-request; it is arbitrated next IDLE cycle.
- Requests are non-preemptive: a higher-priority val never interrupts ISSUE.
- Reset mid-transaction aborts it: no rdy pulse is issued, and target outputs go to 0 immediately.
- wen and ren both set: treated as write (wen drives target, ren forced 0).

Optional Feature:
- Macro CIRNO9_ARB_TIMEOUT_EN.
- When defined: a counter runs in ISSUE. If it reaches TIMEOUT with no target rdy:
  - drop target outputs;
  - load o_rdat = 32'hDEAD_BEEF and set o_err=1;
  - go to DONE and pulse requester rdy.
- o_err clears in the next IDLE. The counter resets on ISSUE entry.
- When undefined: no counter, no o_err port, and ISSUE waits indefinitely.

Decomposition:
- Shared package/define file (cirno9_define.v) holds:
  - state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_DONE=2'd2;
  - grant ids GNT_AXIS, GNT_IFU, GNT_AGU;
  - SRAM_BASE default.
- One sub-module is natural: mem_arb_pick, a combinational priority picker with aging override that outputs a one-hot grant. FSM, latches and routing stay in mem_arb.

Test Plan:
- Single agu write adr=0x8000_0010, wdat=0x1234_5678, wen=4'hF, SRAM rdy=1 → o_sram_wen=4'hF in the ISSUE cycle; hs_arb4agu_rdy pulses 2 cycles after the IDLE cycle; AXI outputs stay 0.
- ifu read pc=0x0000_0100, AXI rdy delayed 5 cycles with rdat=0xCAFE_F00D → hs_arb4axim_val high for 6 cycles; o_rdat=0xCAFE_F00D with hs_arb4ifu_rdy pulse.
- axis, ifu and agu val together → grant order axis, ifu, agu; each rdy is a single pulse, and there is no overlap.
- ifu val continuously re-asserted plus agu pending, STARVE_MAX=8 → agu granted on its 9th arbitration; starve_cnt returns to 0.
- Assert rst_n=0 during ISSUE → all outputs 0 asynchronously; after release, state is IDLE and no stale rdy pulse occurs.
- With CIRNO9_ARB_TIMEOUT_EN and TIMEOUT=16, AXI rdy never asserted → rdy pulse at cycle 17 of ISSUE+1, o_rdat=0xDEAD_BEEF, o_err=1 for one cycle.
